// File: rtl/passcode_entry_fsm_pkg.sv
// Shared types and constants for the passcode entry path.
package passcode_entry_fsm_pkg;

    typedef enum logic [2:0] {
        StEntry,
        StCheck,
        StUnlocked,
        StFail,
        StLockout
    } state_e;

    // Decoder shows "F" for this value.
    localparam logic [3:0]  COUNT_ERR   = 4'hF;
    localparam int unsigned CODE_DIGITS = 4;
    localparam logic [3:0]  BCD_MAX     = 4'd9;

    // Sizes the shared hold timer to the longest of the three hold periods.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/passcode_entry_fsm_if.sv
// Switch/button inputs and decoder/status outputs of the passcode entry stage.
interface passcode_entry_fsm_if #(
    parameter int unsigned MAX_ATTEMPTS = 3
) ();

    localparam int unsigned AttW = $clog2(MAX_ATTEMPTS + 1);

    logic [3:0]      digit_in;
    logic            enter_btn;
    logic            clear_btn;
    logic [3:0]      counter_value;
    logic            unlock;
    logic            locked;
    logic            fail_pulse;
    logic            invalid_digit;
    logic [AttW-1:0] attempts;

    // Switch/button side.
    modport master (
        output digit_in, enter_btn, clear_btn,
        input  counter_value, unlock, locked, fail_pulse, invalid_digit, attempts
    );

    // Entry FSM side.
    modport slave (
        input  digit_in, enter_btn, clear_btn,
        output counter_value, unlock, locked, fail_pulse, invalid_digit, attempts
    );

endinterface

// File: rtl/passcode_entry_fsm_btn_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detector for a debounced button.
// The pulse is one cycle wide and appears three clock edges after the pin rises.
module passcode_entry_fsm_btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q, sync2_q, prev_q, pulse_q;

    // Synchronise the pin and register a pulse on the first synchronised high sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/passcode_entry_fsm.sv
// Passcode entry: collects four BCD digits, checks them against the stored code and
// grants unlock, shows a failure, or locks out after too many consecutive failures.
module passcode_entry_fsm
    import passcode_entry_fsm_pkg::*;
#(
    parameter logic [15:0] PASSCODE           = 16'h1234,
    parameter int unsigned MAX_ATTEMPTS       = 3,
    parameter int unsigned UNLOCK_HOLD_CYCLES = 50000000,
    parameter int unsigned FAIL_HOLD_CYCLES   = 25000000,
    parameter int unsigned LOCKOUT_CYCLES     = 250000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    passcode_entry_fsm_if.slave  bus
);

    localparam int unsigned AttW    = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned HoldMax = max3(UNLOCK_HOLD_CYCLES, FAIL_HOLD_CYCLES, LOCKOUT_CYCLES);
    localparam int unsigned TimerW  = $clog2(HoldMax) + 1;

    // The timer is loaded with hold-1 so the state lasts exactly "hold" cycles.
    localparam logic [TimerW-1:0] UnlockLoad  = TimerW'(UNLOCK_HOLD_CYCLES - 1);
    localparam logic [TimerW-1:0] FailLoad    = TimerW'(FAIL_HOLD_CYCLES - 1);
    localparam logic [TimerW-1:0] LockoutLoad = TimerW'(LOCKOUT_CYCLES - 1);
    localparam logic [AttW:0]     MaxAtt      = (AttW + 1)'(MAX_ATTEMPTS);

    state_e            state_q;
    logic [15:0]       digits_q;
    logic [3:0]        counter_q;
    logic [TimerW-1:0] timer_q;
    logic [AttW-1:0]   attempts_q;
    logic              unlock_q, locked_q, fail_q, invalid_q;

    logic              enter_edge, clear_edge;
    logic [3:0]        count_inc;
    logic [AttW:0]     att_inc;

    passcode_entry_fsm_btn_sync_edge u_enter_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.enter_btn),
        .pulse_o (enter_edge)
    );

    passcode_entry_fsm_btn_sync_edge u_clear_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.clear_btn),
        .pulse_o (clear_edge)
    );

    // Next digit count and next attempt count (one bit wider so saturation is visible).
    always_comb begin
        count_inc = counter_q + 4'd1;
        att_inc   = {1'b0, attempts_q} + 1'b1;
    end

    // Entry FSM with digit register, shared hold timer, attempt counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEntry;
            digits_q   <= '0;
            counter_q  <= '0;
            timer_q    <= '0;
            attempts_q <= '0;
            unlock_q   <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            fail_q    <= 1'b0;
            invalid_q <= 1'b0;
            unique case (state_q)
                StEntry: begin
                    // Clear wins over a simultaneous Enter.
                    if (clear_edge) begin
                        counter_q <= '0;
                        digits_q  <= '0;
                    end else if (enter_edge) begin
                        if (bus.digit_in > BCD_MAX) begin
                            invalid_q <= 1'b1;
                        end else begin
                            digits_q  <= {digits_q[11:0], bus.digit_in};
                            counter_q <= count_inc;
                            if (count_inc == 4'(CODE_DIGITS)) begin
                                state_q <= StCheck;
                            end
                        end
                    end
                end
                StCheck: begin
                    if (digits_q == PASSCODE) begin
                        state_q    <= StUnlocked;
                        unlock_q   <= 1'b1;
                        attempts_q <= '0;
                        timer_q    <= UnlockLoad;
                    end else begin
                        fail_q    <= 1'b1;
                        counter_q <= COUNT_ERR;
                        if (att_inc >= MaxAtt) begin
                            state_q    <= StLockout;
                            locked_q   <= 1'b1;
                            attempts_q <= AttW'(MAX_ATTEMPTS);
                            timer_q    <= LockoutLoad;
                        end else begin
                            state_q    <= StFail;
                            attempts_q <= att_inc[AttW-1:0];
                            timer_q    <= FailLoad;
                        end
                    end
                end
                StUnlocked: begin
                    if (clear_edge || timer_q == '0) begin
                        state_q   <= StEntry;
                        unlock_q  <= 1'b0;
                        counter_q <= '0;
                        digits_q  <= '0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                StFail: begin
                    if (timer_q == '0) begin
                        state_q   <= StEntry;
                        counter_q <= '0;
                        digits_q  <= '0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                StLockout: begin
                    if (timer_q == '0) begin
                        state_q    <= StEntry;
                        locked_q   <= 1'b0;
                        attempts_q <= '0;
                        counter_q  <= '0;
                        digits_q   <= '0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StEntry;
                end
            endcase
        end
    end

    assign bus.counter_value = counter_q;
    assign bus.unlock        = unlock_q;
    assign bus.locked        = locked_q;
    assign bus.fail_pulse    = fail_q;
    assign bus.invalid_digit = invalid_q;
    assign bus.attempts      = attempts_q;

endmodule

// File: tb/tb_passcode_entry_fsm.sv
// Scoreboard bench: the reference model turns each button action into the expected sequence of
// output "runs" (distinct output vectors with their length in cycles, or -1 for don't care);
// the monitor closes a run whenever the outputs change and checks it against the queue.
module tb_passcode_entry_fsm;

    localparam int unsigned UNLOCK = 8;
    localparam int unsigned FAILH  = 4;
    localparam int unsigned LOCK   = 16;
    localparam int unsigned MAXA   = 3;

    typedef struct packed {
        logic [3:0] cnt;
        logic       unl;
        logic       lck;
        logic       fp;
        logic       inv;
        logic [1:0] att;
    } obs_t;

    typedef struct {
        obs_t v;
        int   dur;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    passcode_entry_fsm_if #(.MAX_ATTEMPTS(MAXA)) bus ();

    passcode_entry_fsm #(
        .PASSCODE           (16'h1234),
        .MAX_ATTEMPTS       (MAXA),
        .UNLOCK_HOLD_CYCLES (UNLOCK),
        .FAIL_HOLD_CYCLES   (FAILH),
        .LOCKOUT_CYCLES     (LOCK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t expq[$];
    obs_t last_v;
    int   last_d;
    obs_t cur;
    int   cur_len;
    bit   mon_en = 1'b0;
    bit   cut_unlock = 1'b0;

    // Reference model state: attempts, digits since last clear/attempt.
    int m_att;
    int m_dig[$];

    function automatic obs_t sample();
        obs_t o;
        o.cnt = bus.counter_value;
        o.unl = bus.unlock;
        o.lck = bus.locked;
        o.fp  = bus.fail_pulse;
        o.inv = bus.invalid_digit;
        o.att = bus.attempts;
        return o;
    endfunction

    function automatic obs_t mk(input int cnt, input bit unl, input bit lck, input bit fp,
                                input bit inv, input int att);
        obs_t o;
        o.cnt = 4'(cnt);
        o.unl = unl;
        o.lck = lck;
        o.fp  = fp;
        o.inv = inv;
        o.att = 2'(att);
        return o;
    endfunction

    task automatic push(input obs_t v, input int d);
        exp_t e;
        // An idle vector that is already expected stays one run.
        if (last_d < 0 && d < 0 && last_v == v) return;
        e.v = v;
        e.dur = d;
        expq.push_back(e);
        last_v = v;
        last_d = d;
    endtask

    task automatic m_reset();
        m_att = 0;
        m_dig.delete();
        expq.delete();
        last_d = 0;
        push(mk(0, 0, 0, 0, 0, 0), -1);
    endtask

    task automatic m_clear();
        m_dig.delete();
        push(mk(0, 0, 0, 0, 0, m_att), -1);
    endtask

    task automatic m_enter(input int d);
        int code;
        int n;
        n = m_dig.size();
        if (d > 9) begin
            push(mk(n, 0, 0, 0, 1, m_att), 1);
            push(mk(n, 0, 0, 0, 0, m_att), -1);
        end else begin
            m_dig.push_back(d);
            n = m_dig.size();
            if (n < 4) begin
                push(mk(n, 0, 0, 0, 0, m_att), -1);
            end else begin
                push(mk(4, 0, 0, 0, 0, m_att), 1);
                code = ((m_dig[0] * 10 + m_dig[1]) * 10 + m_dig[2]) * 10 + m_dig[3];
                if (code == 1234) begin
                    push(mk(4, 1, 0, 0, 0, 0), cut_unlock ? -1 : int'(UNLOCK));
                    m_att = 0;
                end else begin
                    m_att++;
                    if (m_att < int'(MAXA)) begin
                        push(mk(15, 0, 0, 1, 0, m_att), 1);
                        push(mk(15, 0, 0, 0, 0, m_att), int'(FAILH) - 1);
                    end else begin
                        push(mk(15, 0, 1, 1, 0, m_att), 1);
                        push(mk(15, 0, 1, 0, 0, m_att), int'(LOCK) - 1);
                        m_att = 0;
                    end
                end
                m_dig.delete();
                push(mk(0, 0, 0, 0, 0, m_att), -1);
            end
        end
    endtask

    task automatic close_run();
        exp_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL run_extra: got %03h for %0d cycles, expected no further change",
                     cur, cur_len);
        end else begin
            e = expq.pop_front();
            if (e.v !== cur) begin
                errors++;
                $display("FAIL run_value: got %03h expected %03h (cnt,unl,lck,fp,inv,att) t=%0t",
                         cur, e.v, $time);
            end
            if (e.dur >= 0) begin
                checks++;
                if (cur_len != e.dur) begin
                    errors++;
                    $display("FAIL run_length: vector %03h lasted %0d cycles, expected %0d",
                             cur, cur_len, e.dur);
                end
            end
        end
    endtask

    // Monitor: track runs of identical outputs and check each one when it ends.
    always @(negedge clk) begin : monitor
        obs_t v;
        if (mon_en) begin
            v = sample();
            if (v !== cur) begin
                close_run();
                cur = v;
                cur_len = 1;
            end else begin
                cur_len++;
            end
        end
    end

    // Digit press; digit_in stays put until the next action so it is stable when consumed.
    task automatic press(input int d, input int hold, input int gap, input bit model);
        if (model) m_enter(d);
        bus.digit_in = 4'(d);
        bus.enter_btn = 1'b1;
        repeat (hold) @(negedge clk);
        bus.enter_btn = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic clr(input int hold, input int gap, input bit model);
        if (model) m_clear();
        bus.clear_btn = 1'b1;
        repeat (hold) @(negedge clk);
        bus.clear_btn = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic code4(input int a, input int b, input int c, input int d);
        press(a, 2, 2, 1'b1);
        press(b, 2, 2, 1'b1);
        press(c, 2, 2, 1'b1);
        press(d, 2, 2, 1'b1);
    endtask

    initial begin
        int gc[4];
        int pos, it, r, hold, gap;
        bit good, done;
        gc = '{1, 2, 3, 4};
        bus.digit_in = 4'd0;
        bus.enter_btn = 1'b0;
        bus.clear_btn = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sample() !== 10'h000) begin
            errors++;
            $display("FAIL reset_state: got %03h expected 000", sample());
        end
        m_reset();
        cur = '0;
        cur_len = 0;
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // Correct code, then one wrong code.
        code4(1, 2, 3, 4);
        repeat (20) @(negedge clk);
        code4(1, 2, 3, 5);
        repeat (15) @(negedge clk);

        // Back to zero attempts, three wrong codes into lockout, presses ignored, then unlock.
        code4(1, 2, 3, 4);
        repeat (20) @(negedge clk);
        code4(1, 2, 3, 5);
        repeat (15) @(negedge clk);
        code4(5, 6, 7, 8);
        repeat (15) @(negedge clk);
        code4(4, 3, 2, 1);
        for (int i = 0; i < 3; i++) press(7, 2, 2, 1'b0);
        repeat (12) @(negedge clk);
        code4(1, 2, 3, 4);
        repeat (20) @(negedge clk);

        // One failure so attempts is non-zero, then invalid digit, held Enter, Clear.
        code4(9, 9, 9, 9);
        repeat (15) @(negedge clk);
        press(10, 2, 2, 1'b1);
        press(1, 10, 2, 1'b1);
        press(2, 2, 2, 1'b1);
        clr(2, 2, 1'b1);
        press(3, 2, 2, 1'b1);
        // Enter and Clear rising together: clear wins, digit dropped.
        m_clear();
        bus.digit_in = 4'd7;
        bus.enter_btn = 1'b1;
        bus.clear_btn = 1'b1;
        repeat (2) @(negedge clk);
        bus.enter_btn = 1'b0;
        bus.clear_btn = 1'b0;
        repeat (3) @(negedge clk);
        code4(1, 2, 3, 4);
        repeat (20) @(negedge clk);

        // Clear during unlock ends it early.
        cut_unlock = 1'b1;
        code4(1, 2, 3, 4);
        clr(2, 2, 1'b0);
        cut_unlock = 1'b0;
        repeat (15) @(negedge clk);

        // Randomised attempts with stray invalid digits and clears.
        for (int a = 0; a < 20; a++) begin
            good = ($urandom_range(2) == 0);
            pos = 0;
            it = 0;
            done = 1'b0;
            while (!done) begin
                r = (it > 8) ? 9 : int'($urandom_range(9));
                hold = int'($urandom_range(1, 3));
                gap = 4 - hold + int'($urandom_range(2));
                if (r == 0 && pos > 0) begin
                    clr(hold, gap, 1'b1);
                    pos = 0;
                end else if (r == 1) begin
                    press(10 + int'($urandom_range(5)), hold, gap, 1'b1);
                end else begin
                    press(good ? gc[pos] : int'($urandom_range(9)), hold, gap, 1'b1);
                    pos++;
                    done = (pos == 4);
                end
                it++;
            end
            repeat (30) @(negedge clk);
        end

        // Drive into lockout, then asynchronous reset between clock edges.
        while (m_att < int'(MAXA) - 1) begin
            code4(9, 8, 7, 6);
            repeat (15) @(negedge clk);
        end
        code4(9, 8, 7, 6);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sample() !== 10'h000) begin
            errors++;
            $display("FAIL async_reset: got %03h expected 000", sample());
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        m_reset();
        cur = '0;
        cur_len = 0;
        mon_en = 1'b1;
        @(negedge clk);
        code4(1, 2, 3, 4);
        repeat (20) @(negedge clk);

        mon_en = 1'b0;
        close_run();
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL run_missing: %0d expected runs never seen, expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
